// File: rtl/jk_ff_bank.sv
// JK register bank built from SR cells with JK-to-SR excitation.
// Optional SR_CONFLICT_CHK_EN adds a sticky s&r conflict checker.
module jk_ff_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [CNT_W-1:0] tog_cnt,
    output logic             all_set,
    output logic             sr_conflict
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_nxt;
    logic             toggle_evt;

    assign s = j & ~q;
    assign r = k & q;

    // SR cell: s&r together is illegal and treated as hold
    always_comb begin
        q_nxt = q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] && !r[i]) begin
                q_nxt[i] = 1'b1;
            end else if (r[i] && !s[i]) begin
                q_nxt[i] = 1'b0;
            end
        end
    end

    assign toggle_evt = en && (|(j & k));

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            tog_cnt <= '0;
            all_set <= 1'b0;
        end else if (en) begin
            q       <= q_nxt;
            all_set <= &q_nxt;
            if (toggle_evt && tog_cnt != CNT_MAX) begin
                tog_cnt <= tog_cnt + 1'b1;
            end
        end
    end

    assign qb = ~q;

`ifdef SR_CONFLICT_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_conflict <= 1'b0;
        end else if (en && (|(s & r))) begin
            sr_conflict <= 1'b1;
        end
    end
`else
    assign sr_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
// Randomized self-checking bench for jk_ff_bank against a behavioural JK model.
module tb_jk_ff_bank;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W-1:0]  j;
    logic [W-1:0]  k;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic [CW-1:0] tog_cnt;
    logic          all_set;
    logic          sr_conflict;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_q;
    int m_cnt;
    int m_all;
    int m_conf;
    bit m_valid = 0;

    jk_ff_bank #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .j(j),
        .k(k),
        .q(q),
        .qb(qb),
        .tog_cnt(tog_cnt),
        .all_set(all_set),
        .sr_conflict(sr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // JK truth table applied per bit, then counter/status rules
    task automatic model_update(input bit r_i, input bit e_i,
                                input int jv, input int kv);
        int nq;
        bit any_tog;
        if (r_i) begin
            m_q = 0; m_cnt = 0; m_all = 0; m_conf = 0;
            m_valid = 1;
            return;
        end
        if (!e_i) return;
        nq = m_q;
        any_tog = 0;
        for (int b = 0; b < W; b++) begin
            case ({jv[b], kv[b]})
                2'b10: nq = nq | (1 << b);
                2'b01: nq = nq & ~(1 << b);
                2'b11: begin
                    nq = nq ^ (1 << b);
                    any_tog = 1;
                end
                default: ;
            endcase
        end
        m_q = nq;
        m_all = (m_q == (1 << W) - 1) ? 1 : 0;
        if (any_tog && m_cnt < CMAX) m_cnt = m_cnt + 1;
    endtask

    task automatic compare_all();
        if (!m_valid) return;
        check("q", 32'(q), 32'(m_q));
        check("qb", 32'(qb), 32'((~m_q) & ((1 << W) - 1)));
        check("tog_cnt", 32'(tog_cnt), 32'(m_cnt));
        check("all_set", 32'(all_set), 32'(m_all));
        check("sr_conflict", 32'(sr_conflict), 32'(m_conf));
    endtask

    task automatic step(input bit r_i, input bit e_i,
                        input logic [W-1:0] jv, input logic [W-1:0] kv);
        rst = r_i; en = e_i; j = jv; k = kv;
        @(posedge clk);
        model_update(r_i, e_i, int'(jv), int'(kv));
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; j = '1; k = '1;
        #2;
        // reset with toggling inputs present
        step(1, 1, 4'hF, 4'hF);
        step(1, 1, 4'hF, 4'hF);
        check("rst_q", 32'(q), 32'h0);
        check("rst_qb", 32'(qb), 32'hF);
        check("rst_cnt", 32'(tog_cnt), 32'h0);
        check("rst_all", 32'(all_set), 32'h0);

        step(0, 1, 4'b0101, 4'b1010);
        check("set_q", 32'(q), 32'h5);
        step(0, 1, 4'h0, 4'h0);
        check("hold_q", 32'(q), 32'h5);
        step(0, 1, 4'h0, 4'hF);
        check("clr_q", 32'(q), 32'h0);

        step(0, 1, 4'b0101, 4'b1010);
        step(0, 1, 4'b1010, 4'b1010);
        check("tog1_q", 32'(q), 32'hF);
        check("tog1_all", 32'(all_set), 32'h1);
        check("tog1_cnt", 32'(tog_cnt), 32'h1);
        step(0, 1, 4'b1010, 4'b1010);
        check("tog2_q", 32'(q), 32'h5);
        check("tog2_all", 32'(all_set), 32'h0);
        check("tog2_cnt", 32'(tog_cnt), 32'h2);

        for (int i = 0; i < 5; i++) step(0, 0, 4'hF, 4'hF);
        check("en_hold_q", 32'(q), 32'h5);
        check("en_hold_cnt", 32'(tog_cnt), 32'h2);

        step(0, 1, 4'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 4'hF, 4'hF);
            check("sat_alt_q", 32'(q), (i % 2 == 0) ? 32'hF : 32'h0);
        end
        check("sat_cnt", 32'(tog_cnt), 32'h7);

        // reset landing mid toggle sequence
        step(0, 1, 4'hF, 4'hF);
        step(1, 1, 4'hF, 4'hF);
        check("midrst_q", 32'(q), 32'h0);
        check("midrst_cnt", 32'(tog_cnt), 32'h0);
        check("midrst_all", 32'(all_set), 32'h0);
        step(0, 1, 4'hF, 4'hF);
        check("post_rst_q", 32'(q), 32'hF);
        check("post_rst_cnt", 32'(tog_cnt), 32'h1);

`ifdef SR_CONFLICT_CHK_EN
        force dut.s = 4'b0001;
        force dut.r = 4'b0001;
        m_conf = 1;
        step(0, 1, 4'h0, 4'h0);
        release dut.s;
        release dut.r;
        check("conf_set", 32'(sr_conflict), 32'h1);
        step(0, 1, 4'h3, 4'h5);
        check("conf_sticky", 32'(sr_conflict), 32'h1);
        step(1, 1, 4'h0, 4'h0);
        check("conf_clr", 32'(sr_conflict), 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_ff_bank.md
# jk_ff_bank

WIDTH-bit JK register bank in which every bit is an SR storage cell driven by JK-to-SR excitation logic (S = J & ~Q, R = K & Q). This is the converse of the existing SR-from-JK cell. The bank is the standard JK storage element for counters and sequencers that want JK semantics on top of the SR primitive. It also keeps a saturating count of toggle cycles and reports bank-level status.

## Interface
- WIDTH, 4, number of JK bits (1..32)
- CNT_W, 8, width of the toggle-event counter

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  update enable; when low, all bits and the counter hold
- j  in  WIDTH  per-bit J inputs
- k  in  WIDTH  per-bit K inputs
- q  out  WIDTH  stored state
- qb  out  WIDTH  complement of q, always equal to ~q
- tog_cnt  out  CNT_W  saturating count of cycles with at least one toggle
- all_set  out  1  registered; high when q is all ones
- sr_conflict  out  1  sticky S&R conflict flag (see Configuration)

## Operation
- Per bit i, internal excitation: s[i] = j[i] & ~q[i], r[i] = k[i] & q[i].
- The SR cell update on a clock edge with en=1:
  - s=1, r=0 → set
  - s=0, r=1 → clear
  - s=0, r=0 → hold
- Resulting JK behaviour per bit:
  - J=0, K=0 → hold
  - J=1, K=0 → set
  - J=0, K=1 → clear
  - J=1, K=1 → toggle
- By construction s and r are never both 1. If both are 1, the design is broken. The SR cell treats that case as hold.
- qb is derived from q. q and qb are never equal.
- Toggle event: en=1 and any bit has j=k=1.
  - On a toggle event, tog_cnt increments by 1 on that edge.
  - tog_cnt saturates at 2^CNT_W−1 and never wraps.
  - Multiple bits toggling in one cycle count once.
- all_set is registered from the next-state value: it is high in the same cycle q becomes all ones.
- en=0: q, tog_cnt and all_set hold regardless of j/k.

## Timing
- Reset, on the first clk edge with rst=1:
  - q=0, qb=all ones
  - tog_cnt=0
  - all_set=0
  - sr_conflict=0
- Reset takes priority over en, j and k.
- Reset asserted mid-sequence clears state on that edge. The first update after reset uses the j/k values sampled on the first edge with rst=0.
- Latency: j/k/en sampled at edge N; q, tog_cnt and all_set reflect the update immediately after edge N. One cycle, no pipeline.
- Inputs need no handshake; every enabled edge is a valid update.
- Counter boundary: at tog_cnt = max with a toggle event, tog_cnt stays at max. q still toggles.

## Configuration
- SR_CONFLICT_CHK_EN
  - Defined: each cycle, a per-bit checker evaluates s&r. If any bit has s&r=1 while en=1, sr_conflict sets on that edge and stays set until rst.
  - Not defined: sr_conflict is tied to 0 and no checker logic is built.
- The macro does not change q, qb, tog_cnt or all_set in either build.

## Test plan
- Reset: drive rst=1 for 2 cycles with j=k=4'hF, en=1 → q=0, qb=4'hF, tog_cnt=0, all_set=0.
- Set/clear/hold: j=4'b0101, k=4'b1010, en=1, one edge → q=4'b0101. Then j=k=0 → q stays 4'b0101. Then j=0, k=4'hF → q=0.
- Toggle and all_set: from q=4'b0101, j=k=4'b1010 → q=4'hF, all_set=1, tog_cnt=1. Repeat once → q=4'b0101, all_set=0, tog_cnt=2.
- Enable hold: en=0, j=k=4'hF for 5 cycles → q, tog_cnt and all_set unchanged.
- Saturation: CNT_W=3, j=k=4'hF, en=1 for 10 cycles → tog_cnt reaches 7 and stays at 7. q alternates 4'hF / 4'h0 each cycle.
- Reset mid-run and conflict flag: rst pulsed during a toggle sequence → all outputs reset on that edge. With SR_CONFLICT_CHK_EN defined, force internal s=r=1 on bit 0 → sr_conflict=1 until the next rst. Under normal j/k stimulus, sr_conflict stays 0.
